// File: rtl/arb_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned DATA_W_DEF = 64;

endpackage

// File: rtl/arb_pick.sv
// Grant selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise data has fixed priority.
module arb_pick
  import arb_pkg::*;
(
  input  logic   if_valid,
  input  logic   d_valid,
  input  owner_t last_grant,
  output owner_t grant
);

  owner_t both_pick;

`ifdef ARB_ROUND_ROBIN_EN
  assign both_pick = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == OWN_D);
  assign both_pick = OWN_D;
`endif

  // A lone requester always wins; contention falls to both_pick.
  always_comb begin
    grant = OWN_IF;
    if (if_valid && d_valid) grant = both_pick;
    else if (d_valid)        grant = OWN_D;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data, one transaction outstanding.
// ARB_ROUND_ROBIN_EN selects round-robin contention handling (default: data priority).
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              rsp_if_valid,
  output logic              rsp_d_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_rsp_valid,
  input  logic [DATA_W-1:0] m_rsp_rdata
);

  state_t            state;
  owner_t            owner;
  owner_t            grant;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              idle;
  logic              fire_if;
  logic              fire_d;
  logic              rsp_hit;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_grant;
`else
  owner_t last_grant;
  assign last_grant = OWN_IF;
`endif

  arb_pick u_pick (
    .if_valid   (if_valid),
    .d_valid    (d_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle     = (state == IDLE);
  assign if_ready = idle && if_valid && (grant == OWN_IF);
  assign d_ready  = idle && d_valid  && (grant == OWN_D);
  assign fire_if  = if_valid && if_ready;
  assign fire_d   = d_valid && d_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= OWN_IF;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fire_if || fire_d) begin
            state   <= REQ;
            owner   <= fire_d ? OWN_D : OWN_IF;
            addr_q  <= fire_d ? d_addr : if_addr;
            we_q    <= fire_d && d_we;
            wdata_q <= fire_d ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= fire_d ? OWN_D : OWN_IF;
`endif
          end
        end
        REQ:     if (m_ready)     state <= WAIT;
        WAIT:    if (m_rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m_valid = (state == REQ);
  assign m_addr  = addr_q;
  assign m_we    = we_q;
  assign m_wdata = wdata_q;

  // Response strobes pass the memory beat straight through in WAIT only.
  assign rsp_hit      = (state == WAIT) && m_rsp_valid;
  assign rsp_if_valid = rsp_hit && (owner == OWN_IF);
  assign rsp_d_valid  = rsp_hit && (owner == OWN_D);
  assign rsp_rdata    = rsp_hit ? m_rsp_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter (honours ARB_ROUND_ROBIN_EN).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_valid, if_ready, d_valid, d_ready, d_we;
  logic [AW-1:0] if_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, rsp_rdata, m_wdata, m_rsp_rdata;
  logic          rsp_if_valid, rsp_d_valid, m_valid, m_ready, m_we, m_rsp_valid;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .rsp_if_valid(rsp_if_valid), .rsp_d_valid(rsp_d_valid), .rsp_rdata(rsp_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } req_t;

  req_t req_q[$];
  int   own_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: port phase 0 free, 1 request presented, 2 awaiting response.
  int            phase = 0;
  int            last = 0;
  bit            fpend = 0, dpend = 0;
  logic [AW-1:0] fa, da;
  logic          dwe;
  logic [DW-1:0] dwd;
  logic          exp_mreq = 1'b0, exp_rsp = 1'b0;
  bit            force_rsp = 0;
  int            req_pct, mrdy_pct, rsp_pct, spur_pct;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
    if (!fpend && $urandom_range(99) < req_pct) begin
      fpend = 1; fa = {$urandom, $urandom};
    end
    if (!dpend && $urandom_range(99) < req_pct) begin
      dpend = 1; da = {$urandom, $urandom}; dwe = 1'($urandom_range(1)); dwd = {$urandom, $urandom};
    end
    if_valid = fpend;
    if_addr  = fpend ? fa : {$urandom, $urandom};
    d_valid  = dpend;
    d_addr   = dpend ? da : {$urandom, $urandom};
    d_we     = dpend ? dwe : 1'($urandom_range(1));
    d_wdata  = dpend ? dwd : {$urandom, $urandom};
    m_ready  = ($urandom_range(99) < mrdy_pct);
    if (phase == 2) m_rsp_valid = ($urandom_range(99) < rsp_pct);
    else            m_rsp_valid = ($urandom_range(99) < spur_pct);
    if (force_rsp) begin
      m_rsp_valid = 1'b1; force_rsp = 0;
    end
    m_rsp_rdata = {$urandom, $urandom};
    exp_mreq = (phase == 1);
    exp_rsp  = (phase == 2) && m_rsp_valid;
  endtask

  task automatic evaluate();
    int g;
    int p;
    @(negedge clk);
    g = -1;
    p = phase;
    if (p == 0) begin
      if (fpend && dpend) g = RR ? ((last == 0) ? 1 : 0) : 1;
      else if (dpend)     g = 1;
      else if (fpend)     g = 0;
    end
    chk("if_ready", if_ready, 64'(g == 0));
    chk("d_ready", d_ready, 64'(g == 1));
    if (g == 0) begin
      req_q.push_back('{addr: fa, we: 1'b0, wdata: '0});
      own_q.push_back(0);
      fpend = 0; last = 0; phase = 1;
    end else if (g == 1) begin
      req_q.push_back('{addr: da, we: dwe, wdata: dwd});
      own_q.push_back(1);
      dpend = 0; last = 1; phase = 1;
    end else if (p == 1 && m_ready) begin
      phase = 2;
    end else if (p == 2 && m_rsp_valid) begin
      phase = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    if_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0; m_rsp_valid = 1'b0;
    exp_mreq = 1'b0; exp_rsp = 1'b0;
    fpend = 0; dpend = 0; phase = 0; last = 0;
    req_q.delete(); own_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_we", m_we, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_rsp_if_valid", rsp_if_valid, 0);
      chk("rst_rsp_d_valid", rsp_d_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    evaluate();
    force_rsp = 1;
  endtask

  // Stimulus and reference model.
  initial begin
    bit did_wait_reset = 0;
    reset = 1'b1;
    if_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0; m_rsp_valid = 1'b0;
    if_addr = '0; d_addr = '0; d_we = 1'b0; d_wdata = '0; m_rsp_rdata = '0;
    do_reset();
    for (int unsigned seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       begin req_pct = 100; mrdy_pct = 100; rsp_pct = 100; spur_pct = 0;  end
        1:       begin req_pct = 50;  mrdy_pct = 40;  rsp_pct = 40;  spur_pct = 15; end
        2:       begin req_pct = 30;  mrdy_pct = 70;  rsp_pct = 70;  spur_pct = 25; end
        default: begin req_pct = 60;  mrdy_pct = 50;  rsp_pct = 50;  spur_pct = 20; end
      endcase
      for (int unsigned cyc = 0; cyc < 600; cyc++) begin
        if (seg == 3 && !did_wait_reset && cyc > 50 && phase == 2) begin
          did_wait_reset = 1;
          do_reset();
        end
        drive();
        evaluate();
      end
    end
    chk("reset_in_wait_exercised", 64'(did_wait_reset), 1);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Monitor: compares memory-side requests and responses against the queues.
  initial begin
    int o;
    forever begin
      @(negedge clk);
      chk("m_valid", m_valid, 64'(exp_mreq));
      if (exp_mreq) begin
        chk("req_queue_nonempty", 64'(req_q.size() != 0), 1);
        if (req_q.size() != 0) begin
          chk("m_addr", m_addr, req_q[0].addr);
          chk("m_we", m_we, 64'(req_q[0].we));
          chk("m_wdata", m_wdata, req_q[0].wdata);
          if (m_ready) void'(req_q.pop_front());
        end
      end
      if (exp_rsp && own_q.size() != 0) begin
        o = own_q.pop_front();
        chk("rsp_if_valid", rsp_if_valid, 64'(o == 0));
        chk("rsp_d_valid", rsp_d_valid, 64'(o == 1));
        chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
      end else begin
        if (exp_rsp) chk("owner_queue_nonempty", 0, 1);
        chk("rsp_if_valid_idle", rsp_if_valid, 0);
        chk("rsp_d_valid_idle", rsp_d_valid, 0);
        chk("rsp_rdata_idle", rsp_rdata, 0);
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- ADDR_W, 64, address width.
- DATA_W, 64, data width.

REQ-002 Ports SHALL be as follows, one per line: name  direction  width  meaning.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- if_valid  in  1  fetch request valid.
- if_ready  out  1  fetch request accepted.
- if_addr  in  ADDR_W  fetch address (PC).
- d_valid  in  1  data request valid.
- d_ready  out  1  data request accepted.
- d_addr  in  ADDR_W  data address.
- d_we  in  1  data write enable.
- d_wdata  in  DATA_W  data write value.
- rsp_if_valid  out  1  fetch response strobe.
- rsp_d_valid  out  1  data response strobe.
- rsp_rdata  out  DATA_W  response data (shared).
- m_valid  out  1  memory request valid.
- m_ready  in  1  memory request accepted.
- m_addr  out  ADDR_W  memory address.
- m_we  out  1  memory write enable.
- m_wdata  out  DATA_W  memory write value.
- m_rsp_valid  in  1  memory response strobe.
- m_rsp_rdata  in  DATA_W  memory read data.

Function
REQ-003 The block SHALL share one memory port between fetch and data, with at most one transaction outstanding.

REQ-004 The FSM SHALL have three states:
- IDLE: accept a request.
- REQ: m_valid high until m_ready.
- WAIT: await m_rsp_valid.

REQ-005 In IDLE, exactly the granted requester's ready SHALL be high, combinationally from the valids; the other ready SHALL be 0. Both readies SHALL be 0 in REQ and WAIT.

REQ-006 On a ready&valid handshake in IDLE, the block SHALL register addr/we/wdata and the owner, and go to REQ next cycle. Fetch requests SHALL register we=0 and wdata=0.

REQ-007 In REQ, m_valid=1 and m_addr/m_we/m_wdata SHALL equal the registered values, stable until m_ready. A cycle with m_valid&m_ready SHALL move to WAIT.

REQ-008 In WAIT, a cycle with m_rsp_valid SHALL:
- pulse the owner's rsp_*_valid for exactly that cycle;
- drive rsp_rdata=m_rsp_rdata combinationally;
- return to IDLE.
Writes also receive a response (an ack; rdata is don't-care).

REQ-009 rsp_rdata SHALL be 0 whenever no rsp_*_valid is high. m_rsp_valid in IDLE or REQ SHALL be ignored.

REQ-010 Minimum latency SHALL be: handshake at cycle 0, m_valid at cycle 1, response at cycle 2 (m_ready=1 at cycle 1, m_rsp_valid=1 at cycle 2). The next handshake SHALL be possible at cycle 3.

REQ-011 Requests presented outside IDLE SHALL be stalled (ready=0), not dropped. Requesters SHALL hold valid/payload until ready.

REQ-012 A single valid requester SHALL always win, regardless of arbitration mode.

Reset
REQ-013 While reset is high, the block SHALL have:
- state=IDLE and owner=fetch;
- last_grant=fetch;
- all registered payloads 0;
- m_valid, rsp_if_valid, rsp_d_valid and rsp_rdata 0.

REQ-014 Reset mid-transaction SHALL abandon the transaction with no response pulse; a late m_rsp_valid after reset SHALL be ignored (IDLE).

Configuration
REQ-015 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last. last_grant SHALL update on every handshake.

REQ-016 Without ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to data (fixed priority). last_grant SHALL be absent, with no other behavioural change.

Structure
REQ-017 A shared package arb_pkg SHALL hold:
- the state enum (IDLE, REQ, WAIT);
- the owner enum (OWN_IF, OWN_D);
- default ADDR_W/DATA_W constants.

REQ-018 Grant selection SHALL be one combinational sub-module, arb_pick, with inputs if_valid, d_valid and last_grant, and output grant. The macro SHALL apply inside arb_pick.

Verification
REQ-019 Scenario: reset, then if_valid=1 with if_addr=0x1000, memory with m_ready=1 and 1-cycle response 0xD503201F. Required: if_ready at cycle 0; m_addr=0x1000, m_we=0 at cycle 1; rsp_if_valid=1, rsp_rdata=0xD503201F at cycle 2.

REQ-020 Scenario: d_valid, d_we=1, d_addr=0x2008, d_wdata=0xCAFE, with m_ready held 0 for 3 cycles. Required: m_valid and the payload stable 3 cycles; rsp_d_valid pulses once after the ack; rsp_if_valid never pulses.

REQ-021 Scenario: both valid continuously for 4 transactions. Required with the macro: grants D, IF, D, IF. Required without the macro: D, D, D, D.

REQ-022 Scenario: if_valid asserted during a data transaction in WAIT. Required: if_ready=0 until IDLE, then fetch granted; no request lost.

REQ-023 Scenario: reset asserted in WAIT, then m_rsp_valid=1 one cycle after reset deasserts. Required: no rsp_*_valid pulse; all outputs 0 during reset.

REQ-024 Scenario: m_rsp_valid=1 in IDLE with no requests. Required: no response strobe; state stays IDLE.
